// File: rtl/cond_check_stage_if.sv
// ID/EXE boundary signals for the condition-check stage.
// The master side is the pipeline control/ID/status logic; the slave side is the stage.
interface cond_check_stage_if;
    logic       stall;
    logic       flush;
    logic       id_valid;
    logic [3:0] id_cond;
    logic       id_s;
    logic [3:0] sr_q;
    logic       sr_wr_en;
    logic [3:0] sr_wr_data;
    logic       exe_valid;
    logic       exe_exec;
    logic       exe_s_en;

    modport master (
        output stall, flush, id_valid, id_cond, id_s, sr_q, sr_wr_en, sr_wr_data,
        input  exe_valid, exe_exec, exe_s_en
    );

    modport slave (
        input  stall, flush, id_valid, id_cond, id_s, sr_q, sr_wr_en, sr_wr_data,
        output exe_valid, exe_exec, exe_s_en
    );
endinterface

// File: rtl/cond_check_stage.sv
// Evaluates the instruction condition against bypassed NZCV flags and registers the
// execute/annul decision for EXE. COND_STATS_EN adds a saturating annulled-instruction counter.
module cond_check_stage
`ifdef COND_STATS_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic              clk,
    input  logic              rst,
    cond_check_stage_if.slave bus
`ifdef COND_STATS_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  fail_cnt
`endif
);

    typedef enum logic [1:0] {
        ModeCapture,
        ModeHold,
        ModeBubble
    } mode_e;

    mode_e      mode;
    logic [3:0] flags;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       pass;

    logic valid_q, valid_d;
    logic exec_q, exec_d;
    logic s_en_q, s_en_d;

    // A flag write committing this cycle must be seen by the instruction behind it.
    always_comb begin
        flags  = bus.sr_wr_en ? bus.sr_wr_data : bus.sr_q;
        flag_n = flags[3];
        flag_z = flags[2];
        flag_c = flags[1];
        flag_v = flags[0];
    end

    always_comb begin
        pass = 1'b0;
        unique case (bus.id_cond)
            4'h0: pass = flag_z;
            4'h1: pass = !flag_z;
            4'h2: pass = flag_c;
            4'h3: pass = !flag_c;
            4'h4: pass = flag_n;
            4'h5: pass = !flag_n;
            4'h6: pass = flag_v;
            4'h7: pass = !flag_v;
            4'h8: pass = flag_c && !flag_z;
            4'h9: pass = !flag_c || flag_z;
            4'hA: pass = (flag_n == flag_v);
            4'hB: pass = (flag_n != flag_v);
            4'hC: pass = !flag_z && (flag_n == flag_v);
            4'hD: pass = flag_z || (flag_n != flag_v);
            4'hE: pass = 1'b1;
            4'hF: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

    // Flush takes precedence over stall.
    always_comb begin
        if (bus.flush) begin
            mode = ModeBubble;
        end else if (bus.stall) begin
            mode = ModeHold;
        end else begin
            mode = ModeCapture;
        end
    end

    always_comb begin
        valid_d = valid_q;
        exec_d  = exec_q;
        s_en_d  = s_en_q;
        unique case (mode)
            ModeCapture: begin
                valid_d = bus.id_valid;
                exec_d  = bus.id_valid && pass;
                s_en_d  = bus.id_valid && bus.id_s && pass;
            end
            ModeBubble: begin
                valid_d = 1'b0;
                exec_d  = 1'b0;
                s_en_d  = 1'b0;
            end
            default: begin
                valid_d = valid_q;
                exec_d  = exec_q;
                s_en_d  = s_en_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            exec_q  <= 1'b0;
            s_en_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            exec_q  <= exec_d;
            s_en_q  <= s_en_d;
        end
    end

    assign bus.exe_valid = valid_q;
    assign bus.exe_exec  = exec_q;
    assign bus.exe_s_en  = s_en_q;

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear is honoured on flush cycles but not on stall; only captured annuls count.
    always_comb begin
        cnt_d = cnt_q;
        if (mode != ModeHold) begin
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (mode == ModeCapture && bus.id_valid && !pass && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fail_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cond_check_stage.sv
// Scoreboard bench for cond_check_stage: driver pushes model predictions, monitor pops and
// compares one cycle later. Counter checks are active when COND_STATS_EN is defined.
module tb_cond_check_stage;

    localparam int CntW   = 4;
    localparam int CntMax = (1 << CntW) - 1;

    typedef struct {
        logic v;
        logic x;
        logic s;
        int   cnt;
    } exp_t;

    logic clk;
    logic rst;
    cond_check_stage_if bus ();

`ifdef COND_STATS_EN
    logic            cnt_clr;
    logic [CntW-1:0] fail_cnt;

    cond_check_stage #(.CNT_W(CntW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cnt_clr  (cnt_clr),
        .fail_cnt (fail_cnt)
    );
`else
    cond_check_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t q_exp[$];

    // Reference state
    logic m_v, m_x, m_s;
    int   m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ARM condition rule: pairs share a base test, odd codes invert; E always, F never.
    function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        int pair;
        n    = f[3];
        z    = f[2];
        c    = f[1];
        v    = f[0];
        pair = int'(cond) / 2;
        case (pair)
            0:       base = z;
            1:       base = c;
            2:       base = n;
            3:       base = v;
            4:       base = c && !z;
            5:       base = (n == v);
            6:       base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        return (int'(cond) % 2 == 1) ? !base : base;
    endfunction

    task automatic step(input logic v, input logic [3:0] c, input logic s, input logic [3:0] q,
                        input logic we, input logic [3:0] wd, input logic st, input logic fl,
                        input logic clr);
        logic p;
        exp_t e;
        @(negedge clk);
        bus.id_valid   = v;
        bus.id_cond    = c;
        bus.id_s       = s;
        bus.sr_q       = q;
        bus.sr_wr_en   = we;
        bus.sr_wr_data = wd;
        bus.stall      = st;
        bus.flush      = fl;
`ifdef COND_STATS_EN
        cnt_clr = clr;
`endif
        p = ref_pass(c, we ? wd : q);
        if (!(st && !fl)) begin
            if (clr) m_cnt = 0;
            else if (!fl && v && !p && m_cnt < CntMax) m_cnt = m_cnt + 1;
        end
        if (fl) begin
            m_v = 1'b0; m_x = 1'b0; m_s = 1'b0;
        end else if (!st) begin
            m_v = v; m_x = v && p; m_s = v && s && p;
        end
        e.v = m_v; e.x = m_x; e.s = m_s; e.cnt = m_cnt;
        q_exp.push_back(e);
    endtask

    task automatic rand_step(input int stall_pct, input int flush_pct, input int clr_pct);
        step(($urandom_range(99) < 80) ? 1'b1 : 1'b0, 4'($urandom_range(15)),
             1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)),
             4'($urandom_range(15)),
             (int'($urandom_range(99)) < stall_pct) ? 1'b1 : 1'b0,
             (int'($urandom_range(99)) < flush_pct) ? 1'b1 : 1'b0,
             (int'($urandom_range(99)) < clr_pct) ? 1'b1 : 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_exe_valid"}, int'(bus.exe_valid), 0);
        chk({tag, "_exe_exec"}, int'(bus.exe_exec), 0);
        chk({tag, "_exe_s_en"}, int'(bus.exe_s_en), 0);
`ifdef COND_STATS_EN
        chk({tag, "_fail_cnt"}, int'(fail_cnt), 0);
`endif
    endtask

    // Monitor: the DUT presents a new decision after every rising edge out of reset.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst && q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("exe_valid", int'(bus.exe_valid), int'(e.v));
            chk("exe_exec", int'(bus.exe_exec), int'(e.x));
            chk("exe_s_en", int'(bus.exe_s_en), int'(e.s));
`ifdef COND_STATS_EN
            chk("fail_cnt", int'(fail_cnt), e.cnt);
`endif
        end
    end

    initial begin
        m_v = 1'b0; m_x = 1'b0; m_s = 1'b0; m_cnt = 0;
        rst            = 1'b0;
        bus.id_valid   = 1'b1;
        bus.id_cond    = 4'hE;
        bus.id_s       = 1'b1;
        bus.sr_q       = 4'h0;
        bus.sr_wr_en   = 1'b0;
        bus.sr_wr_data = 4'h0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
`ifdef COND_STATS_EN
        cnt_clr = 1'b0;
`endif
        // Reset held across edges with an always-pass instruction present
        repeat (3) @(posedge clk);
        #3;
        check_zero("reset");
        #1;
        rst = 1'b1;
        step(1, 4'hE, 1, 4'h0, 0, 4'h0, 0, 0, 0);

        // Full NZCV x cond sweep
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                step(1, 4'(c), 1, 4'(f), 0, 4'($urandom_range(15)), 0, 0, 0);
            end
        end
        // Same sweep through the bypass path with a misleading sr_q
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                step(1, 4'(c), 1'($urandom_range(1)), ~4'(f), 1, 4'(f), 0, 0, 0);
            end
        end

        // Bypass directed: Z comes only from the write data
        step(1, 4'h0, 1, 4'b0000, 1, 4'b0100, 0, 0, 0);
        step(1, 4'h0, 1, 4'b0000, 0, 4'b0100, 0, 0, 0);
        // Invalid instruction with always-pass cond
        step(0, 4'hE, 1, 4'h0, 0, 4'h0, 0, 0, 0);

        // Stall holds a passing capture, then stall+flush bubbles
        step(1, 4'hE, 1, 4'h0, 0, 4'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) rand_step(100, 0, 0);
        step(1, 4'hE, 1, 4'h0, 0, 4'h0, 1, 1, 0);

        // Counter: saturation, clear vs increment, no count under stall or flush
        for (int i = 0; i < 20; i++) step(1, 4'hF, 0, 4'h0, 0, 4'h0, 0, 0, 0);
        step(1, 4'hF, 0, 4'h0, 0, 4'h0, 0, 0, 1);
        step(1, 4'hF, 0, 4'h0, 0, 4'h0, 1, 0, 0);
        step(1, 4'hF, 0, 4'h0, 0, 4'h0, 0, 1, 0);
        step(1, 4'hF, 0, 4'h0, 0, 4'h0, 0, 0, 0);
        step(1, 4'hE, 0, 4'h0, 0, 4'h0, 1, 0, 1);
        step(1, 4'hF, 0, 4'h0, 0, 4'h0, 1, 1, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) rand_step(20, 10, 5);

        // Asynchronous reset in the middle of a stall
        step(1, 4'hE, 1, 4'h0, 0, 4'h0, 0, 0, 0);
        step(1, 4'hF, 0, 4'h0, 0, 4'h0, 1, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero("midreset");
        m_v = 1'b0; m_x = 1'b0; m_s = 1'b0; m_cnt = 0;
        rst = 1'b1;
        for (int i = 0; i < 40; i++) rand_step(20, 10, 5);

        @(posedge clk);
        #2;
        chk("queue_drained", q_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
